// File: rtl/riscv_lsu_split_if.sv
// ---------------------------------------------------------------------------
// riscv_lsu_split_if.sv
//
// Bus bundles for the split-capable load/store unit.
//
// riscv_lsu_core_if : memory stage <-> LSU
//   req    request, held by the core while stall = 1
//   we     1 = store
//   size   funct3 size code (B/H/W/D/BU/HU/WU)
//   addr   byte address
//   wd     store data, LSB-justified
//   rd     load result, sign/zero-extended (0 for stores)
//   stall  core must hold its request
//   err    misaligned-with-splitting-off or illegal size, single cycle
//
// riscv_lsu_mem_if : LSU <-> data memory port
//   req    beat request
//   we     beat is a write
//   be     byte enables, one per lane
//   addr   beat address, aligned to the bus word
//   wd     lane-positioned write data
//   rd     read data, valid with ready
//   ready  beat completes this cycle
// ---------------------------------------------------------------------------
interface riscv_lsu_core_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [2:0]        size;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rd;
    logic              stall;
    logic              err;

    modport master (output req, we, size, addr, wd, input  rd, stall, err);
    modport slave  (input  req, we, size, addr, wd, output rd, stall, err);
endinterface

interface riscv_lsu_mem_if #(
    parameter int DATA_W = 32
);
    localparam int BYTES = DATA_W / 8;

    logic              req;
    logic              we;
    logic [BYTES-1:0]  be;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rd;
    logic              ready;

    modport master (output req, we, be, addr, wd, input  rd, ready);
    modport slave  (input  req, we, be, addr, wd, output rd, ready);
endinterface

// File: rtl/riscv_lsu_split.sv
// ---------------------------------------------------------------------------
// riscv_lsu_split.sv
//
// Load/store unit that turns one core access into one or two aligned memory
// beats. An access whose bytes cross a bus-word boundary is issued as a LO
// beat (base) and a HI beat (base + BYTES) and the read data is reassembled;
// with MISALIGN_EN = 0 such an access is rejected on core.err instead.
//
// Ports:
//   clk_i   rising-edge clock
//   rst_ni  asynchronous active-low reset
//   core    riscv_lsu_core_if.slave  (request / stall / result)
//   mem     riscv_lsu_mem_if.master  (beat request / ready / read data)
//
// Parameters:
//   DATA_W       32 or 64
//   MISALIGN_EN  1 = split boundary-crossing accesses, 0 = flag them
// ---------------------------------------------------------------------------
module riscv_lsu_split #(
    parameter int DATA_W      = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    riscv_lsu_core_if.slave core,
    riscv_lsu_mem_if.master mem
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_e;

    state_e            state_q;
    logic              we_q;
    logic [2:0]        size_q;
    logic [OFF_W-1:0]  off_q;
    logic [31:0]       base_q;
    logic [DATA_W-1:0] wd_q;
    logic              split_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] rd_q;

    function automatic logic [3:0] size_bytes(input logic [2:0] size);
        case (size)
            3'd0, 3'd4: return 4'd1;
            3'd1, 3'd5: return 4'd2;
            3'd2, 3'd6: return 4'd4;
            default:    return 4'd8;
        endcase
    endfunction

    // Shift the two-word window down to the accessed bytes, then extend.
    function automatic logic [DATA_W-1:0] extract(input logic [2*DATA_W-1:0] pair,
                                                  input logic [OFF_W-1:0]    off,
                                                  input logic [2:0]          size);
        logic [2*DATA_W-1:0] sh;
        sh = pair >> {off, 3'b000};
        case (size)
            3'd0:    return DATA_W'($signed(sh[7:0]));
            3'd1:    return DATA_W'($signed(sh[15:0]));
            3'd2:    return DATA_W'($signed(sh[31:0]));
            3'd4:    return DATA_W'(sh[7:0]);
            3'd5:    return DATA_W'(sh[15:0]);
            3'd6:    return DATA_W'(sh[31:0]);
            default: return sh[DATA_W-1:0];
        endcase
    endfunction

    // ---------------- request decode (IDLE only) ----------------
    logic [OFF_W-1:0] req_off;
    logic             req_illegal;
    logic             req_split;
    logic             req_reject;

    assign req_off = core.addr[OFF_W-1:0];

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves a latch.
        req_illegal = (core.size == 3'd7) ||
                      ((DATA_W == 32) && ((core.size == 3'd3) || (core.size == 3'd6)));
        req_split   = (5'(req_off) + 5'(size_bytes(core.size))) > 5'(BYTES);
        req_reject  = req_illegal || (req_split && !MISALIGN_EN);
    end

    // ---------------- core side ----------------
    always_comb begin
        core.err   = 1'b0;
        core.stall = 1'b0;
        if (!rst_ni) begin
            // Held in reset: nothing is accepted, so the core must keep waiting.
            core.stall = core.req;
        end else begin
            case (state_q)
                IDLE: begin
                    core.err   = core.req && req_reject;
                    core.stall = core.req && !req_reject;
                end
                LO, HI:  core.stall = 1'b1;
                default: core.stall = 1'b0;
            endcase
        end
    end

    assign core.rd = rd_q;

    // ---------------- lane placement over a two-word window ----------------
    logic [2*BYTES-1:0]  be_wide;
    logic [2*DATA_W-1:0] wd_wide;

    assign be_wide = (((2*BYTES)'(1) << size_bytes(size_q)) - (2*BYTES)'(1)) << off_q;
    assign wd_wide = {{DATA_W{1'b0}}, wd_q} << {off_q, 3'b000};

    // Beat outputs decode only registered state, so they stay stable until ready.
    always_comb begin
        mem.req  = 1'b0;
        mem.we   = 1'b0;
        mem.be   = '0;
        mem.addr = '0;
        mem.wd   = '0;
        case (state_q)
            LO: begin
                mem.req  = 1'b1;
                mem.we   = we_q;
                mem.be   = be_wide[BYTES-1:0];
                mem.addr = base_q;
                mem.wd   = wd_wide[DATA_W-1:0];
            end
            HI: begin
                mem.req  = 1'b1;
                mem.we   = we_q;
                mem.be   = be_wide[2*BYTES-1:BYTES];
                mem.addr = base_q + 32'(BYTES);   // wraps at 2^32
                mem.wd   = wd_wide[2*DATA_W-1:DATA_W];
            end
            default: ;
        endcase
    end

    // ---------------- FSM and datapath registers ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= '0;
            off_q   <= '0;
            base_q  <= '0;
            wd_q    <= '0;
            split_q <= 1'b0;
            // NOTE: read buffers are cleared too, so a fresh access never exposes bytes of an abandoned one.
            lo_q    <= '0;
            hi_q    <= '0;
            rd_q    <= '0;
        end else begin
            // NOTE: non-blocking throughout, so each register samples pre-edge values.
            case (state_q)
                IDLE: begin
                    if (core.req && !req_reject) begin
                        we_q    <= core.we;
                        size_q  <= core.size;
                        off_q   <= req_off;
                        base_q  <= {core.addr[31:OFF_W], {OFF_W{1'b0}}};
                        wd_q    <= core.wd;
                        split_q <= req_split;
                        state_q <= LO;
                    end
                end
                LO: begin
                    if (mem.ready) begin
                        lo_q <= mem.rd;
                        if (split_q) begin
                            state_q <= HI;
                        end else begin
                            // The access fits in this word, so hi_q bytes are never selected.
                            rd_q    <= we_q ? '0 : extract({hi_q, mem.rd}, off_q, size_q);
                            state_q <= RESP;
                        end
                    end
                end
                HI: begin
                    if (mem.ready) begin
                        hi_q    <= mem.rd;
                        rd_q    <= we_q ? '0 : extract({mem.rd, lo_q}, off_q, size_q);
                        state_q <= RESP;
                    end
                end
                default: state_q <= IDLE;   // RESP: request still present belongs to this access
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_lsu_split.sv
// ---------------------------------------------------------------------------
// tb_riscv_lsu_split.sv
//
// Directed bench for riscv_lsu_split. Three instances share clock and reset:
//   A: DATA_W=32, MISALIGN_EN=1 with a byte-enable memory and programmable wait states
//   B: DATA_W=32, MISALIGN_EN=0 (error path only, memory never ready)
//   C: DATA_W=64, MISALIGN_EN=1 with a read-only memory
// Memory contents: 0x100 = 44332211, 0x104 = 88776655 (A);
// 0x100 = 8877665544332211, 0x108 = 00FFEEDDCCBBAA99 (C).
// ---------------------------------------------------------------------------
module tb_riscv_lsu_split;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    riscv_lsu_core_if #(.DATA_W(32)) ca ();
    riscv_lsu_mem_if  #(.DATA_W(32)) ma ();
    riscv_lsu_core_if #(.DATA_W(32)) cb ();
    riscv_lsu_mem_if  #(.DATA_W(32)) mb ();
    riscv_lsu_core_if #(.DATA_W(64)) cc ();
    riscv_lsu_mem_if  #(.DATA_W(64)) mc ();

    riscv_lsu_split #(.DATA_W(32), .MISALIGN_EN(1'b1)) dut_a (.clk_i(clk), .rst_ni(rst_n), .core(ca), .mem(ma));
    riscv_lsu_split #(.DATA_W(32), .MISALIGN_EN(1'b0)) dut_b (.clk_i(clk), .rst_ni(rst_n), .core(cb), .mem(mb));
    riscv_lsu_split #(.DATA_W(64), .MISALIGN_EN(1'b1)) dut_c (.clk_i(clk), .rst_ni(rst_n), .core(cc), .mem(mc));

    // ---------------- memory model A ----------------
    logic [31:0] mem_a [0:63];
    int          delay_a = 0;
    int          wait_a;

    assign ma.ready = ma.req && (wait_a >= delay_a);
    assign ma.rd    = mem_a[ma.addr[7:2]];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mem_a[i] <= '0;
            mem_a[0]  <= 32'h44332211;
            mem_a[1]  <= 32'h88776655;
            mem_a[63] <= 32'hBEEF0000;
            wait_a    <= 0;
        end else begin
            if (ma.req && !ma.ready) wait_a <= wait_a + 1;
            else                     wait_a <= 0;
            if (ma.req && ma.ready && ma.we)
                for (int b = 0; b < 4; b++)
                    if (ma.be[b]) mem_a[ma.addr[7:2]][8*b +: 8] <= ma.wd[8*b +: 8];
        end
    end

    // Beat log and stability monitor for A, sampled mid-cycle.
    logic [31:0] log_addr [0:15];
    logic [3:0]  log_be   [0:15];
    logic [31:0] log_wd   [0:15];
    logic        log_we   [0:15];
    int          beat_a     = 0;
    int          unstable_a = 0;
    logic        pend_a     = 1'b0;
    logic [69:0] snap_a     = '0;

    always @(negedge clk) begin
        if (pend_a && ({ma.req, ma.we, ma.be, ma.addr, ma.wd} !== snap_a)) unstable_a <= unstable_a + 1;
        pend_a <= ma.req && !ma.ready;
        snap_a <= {ma.req, ma.we, ma.be, ma.addr, ma.wd};
        if (ma.req && ma.ready) begin
            log_addr[beat_a % 16] <= ma.addr;
            log_be[beat_a % 16]   <= ma.be;
            log_wd[beat_a % 16]   <= ma.wd;
            log_we[beat_a % 16]   <= ma.we;
            beat_a                <= beat_a + 1;
        end
    end

    // ---------------- instance B: memory never answers ----------------
    int req_b = 0;
    assign mb.ready = 1'b0;
    assign mb.rd    = '0;
    always @(negedge clk) if (mb.req) req_b <= req_b + 1;

    // ---------------- memory model C ----------------
    logic [63:0] mem_c [0:31];
    logic [31:0] logc_addr [0:3];
    logic [7:0]  logc_be   [0:3];
    int          beat_c = 0;

    initial begin
        for (int i = 0; i < 32; i++) mem_c[i] = '0;
        mem_c[0] = 64'h88776655_44332211;
        mem_c[1] = 64'h00FFEEDD_CCBBAA99;
    end

    assign mc.ready = mc.req;
    assign mc.rd    = mem_c[mc.addr[7:3]];

    always @(negedge clk) begin
        if (mc.req && mc.ready) begin
            logc_addr[beat_c % 4] <= mc.addr;
            logc_be[beat_c % 4]   <= mc.be;
            beat_c                <= beat_c + 1;
        end
    end

    // ---------------- drivers ----------------
    // Leaves the request asserted after RESP so a follow-up call is back-to-back.
    task automatic access_a(input logic we, input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] wd, output logic [31:0] rd, output int stalls,
                            output logic err);
        logic done;
        @(posedge clk); #1;
        ca.req = 1'b1; ca.we = we; ca.size = size; ca.addr = addr; ca.wd = wd;
        rd = 'x; stalls = 0; err = 1'b0; done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ca.err) err = 1'b1;
            if (ca.stall) stalls++;
            else begin
                rd = ca.rd; done = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!done) begin n_fail++; $display("FAIL access_a_timeout: addr %h never completed, required completion within 40 cycles", addr); end
    endtask

    task automatic idle_a();
        @(posedge clk); #1;
        ca.req = 1'b0;
    endtask

    task automatic access_c(input logic [2:0] size, input logic [31:0] addr,
                            output logic [63:0] rd, output int stalls);
        logic done;
        @(posedge clk); #1;
        cc.req = 1'b1; cc.we = 1'b0; cc.size = size; cc.addr = addr; cc.wd = '0;
        rd = 'x; stalls = 0; done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cc.stall) stalls++;
            else begin
                rd = cc.rd; done = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        cc.req = 1'b0;
        n_tests++;
        if (!done) begin n_fail++; $display("FAIL access_c_timeout: addr %h never completed, required completion within 40 cycles", addr); end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        ca.req = 1'b1; ca.we = 1'b0; ca.size = 3'd2; ca.addr = 32'h100; ca.wd = '0;
        cb.req = 1'b1; cb.we = 1'b0; cb.size = 3'd7; cb.addr = 32'h100; cb.wd = '0;
        cc.req = 1'b0; cc.we = 1'b0; cc.size = 3'd0; cc.addr = '0;     cc.wd = '0;
        @(negedge clk);
        n_tests++; if (ca.stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall_follows_req: got %b want 1", ca.stall); end
        n_tests++; if (ma.req !== 1'b0)   begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", ma.req); end
        n_tests++; if (ca.rd !== 32'h0)   begin n_fail++; $display("FAIL reset_rd: got %h want 00000000", ca.rd); end
        n_tests++; if (cb.err !== 1'b0)   begin n_fail++; $display("FAIL reset_err: got %b want 0", cb.err); end
        ca.req = 1'b0; cb.req = 1'b0;
        #1;
        n_tests++; if (ca.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall_no_req: got %b want 0", ca.stall); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_lw_aligned();
        logic [31:0] rd; int st; logic er; int s;
        s = beat_a;
        access_a(1'b0, 3'd2, 32'h100, '0, rd, st, er);
        idle_a();
        n_tests++; if (rd !== 32'h44332211)   begin n_fail++; $display("FAIL lw_aligned_rd: got %h want 44332211", rd); end
        n_tests++; if (st != 2)               begin n_fail++; $display("FAIL lw_aligned_stall: got %0d want 2", st); end
        n_tests++; if (beat_a - s != 1)       begin n_fail++; $display("FAIL lw_aligned_beats: got %0d want 1", beat_a - s); end
        n_tests++; if (log_addr[s % 16] !== 32'h100 || log_be[s % 16] !== 4'hF)
            begin n_fail++; $display("FAIL lw_aligned_beat: got addr %h be %b want 00000100 1111", log_addr[s % 16], log_be[s % 16]); end
    endtask

    task automatic test_split_loads();
        logic [31:0] rd; int st; logic er; int s;
        s = beat_a;
        access_a(1'b0, 3'd2, 32'h102, '0, rd, st, er);
        idle_a();
        n_tests++; if (rd !== 32'h66554433) begin n_fail++; $display("FAIL lw_split_rd: got %h want 66554433", rd); end
        n_tests++; if (st != 3)             begin n_fail++; $display("FAIL lw_split_stall: got %0d want 3", st); end
        n_tests++; if (beat_a - s != 2 || log_addr[s % 16] !== 32'h100 || log_be[s % 16] !== 4'b1100 ||
                       log_addr[(s + 1) % 16] !== 32'h104 || log_be[(s + 1) % 16] !== 4'b0011)
            begin n_fail++; $display("FAIL lw_split_beats: got n=%0d %h/%b %h/%b want 2 00000100/1100 00000104/0011",
                  beat_a - s, log_addr[s % 16], log_be[s % 16], log_addr[(s + 1) % 16], log_be[(s + 1) % 16]); end

        s = beat_a;
        access_a(1'b0, 3'd1, 32'h103, '0, rd, st, er);
        idle_a();
        n_tests++; if (rd !== 32'h00005544) begin n_fail++; $display("FAIL lh_split_rd: got %h want 00005544", rd); end
        n_tests++; if (log_be[s % 16] !== 4'b1000 || log_be[(s + 1) % 16] !== 4'b0001)
            begin n_fail++; $display("FAIL lh_split_be: got %b %b want 1000 0001", log_be[s % 16], log_be[(s + 1) % 16]); end

        s = beat_a;
        access_a(1'b0, 3'd0, 32'h107, '0, rd, st, er);
        idle_a();
        n_tests++; if (rd !== 32'hFFFFFF88) begin n_fail++; $display("FAIL lb_sext_rd: got %h want ffffff88", rd); end
        n_tests++; if (st != 2 || beat_a - s != 1)
            begin n_fail++; $display("FAIL lb_single_beat: got stall %0d beats %0d want 2 1", st, beat_a - s); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd; int st; logic er; int s;
        s = beat_a;
        access_a(1'b0, 3'd2, 32'hFFFF_FFFE, '0, rd, st, er);
        idle_a();
        n_tests++; if (log_addr[s % 16] !== 32'hFFFF_FFFC || log_addr[(s + 1) % 16] !== 32'h0)
            begin n_fail++; $display("FAIL wrap_addr: got %h %h want fffffffc 00000000", log_addr[s % 16], log_addr[(s + 1) % 16]); end
        n_tests++; if (rd !== 32'h2211BEEF) begin n_fail++; $display("FAIL wrap_rd: got %h want 2211beef", rd); end
    endtask

    task automatic test_store();
        logic [31:0] rd; int st; logic er; int s;
        s = beat_a;
        access_a(1'b1, 3'd2, 32'h101, 32'hAABBCCDD, rd, st, er);
        idle_a();
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL sw_rd_zero: got %h want 00000000", rd); end
        n_tests++; if (log_addr[s % 16] !== 32'h100 || log_be[s % 16] !== 4'b1110 ||
                       log_wd[s % 16] !== 32'hBBCCDD00 || log_we[s % 16] !== 1'b1)
            begin n_fail++; $display("FAIL sw_lo_beat: got %h %b %h we=%b want 00000100 1110 bbccdd00 1",
                  log_addr[s % 16], log_be[s % 16], log_wd[s % 16], log_we[s % 16]); end
        n_tests++; if (log_addr[(s + 1) % 16] !== 32'h104 || log_be[(s + 1) % 16] !== 4'b0001 ||
                       log_wd[(s + 1) % 16] !== 32'h000000AA)
            begin n_fail++; $display("FAIL sw_hi_beat: got %h %b %h want 00000104 0001 000000aa",
                  log_addr[(s + 1) % 16], log_be[(s + 1) % 16], log_wd[(s + 1) % 16]); end
        access_a(1'b0, 3'd2, 32'h101, '0, rd, st, er);
        idle_a();
        n_tests++; if (rd !== 32'hAABBCCDD) begin n_fail++; $display("FAIL sw_readback: got %h want aabbccdd", rd); end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; int st; logic er; int s; int u;
        delay_a = 3;
        s = beat_a; u = unstable_a;
        access_a(1'b0, 3'd4, 32'h107, '0, rd, st, er);
        idle_a();
        delay_a = 0;
        n_tests++; if (rd !== 32'h00000088) begin n_fail++; $display("FAIL lbu_wait_rd: got %h want 00000088", rd); end
        n_tests++; if (st != 5)             begin n_fail++; $display("FAIL lbu_wait_stall: got %0d want 5", st); end
        n_tests++; if (log_addr[s % 16] !== 32'h104 || log_be[s % 16] !== 4'b1000)
            begin n_fail++; $display("FAIL lbu_wait_beat: got %h %b want 00000104 1000", log_addr[s % 16], log_be[s % 16]); end
        n_tests++; if (unstable_a != u)     begin n_fail++; $display("FAIL lbu_wait_stable: got %0d changes want 0", unstable_a - u); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd1, rd2; int st1, st2; logic er;
        access_a(1'b0, 3'd2, 32'h100, '0, rd1, st1, er);
        access_a(1'b0, 3'd0, 32'h102, '0, rd2, st2, er);
        idle_a();
        n_tests++; if (rd1 !== 32'hBBCCDD11 || st1 != 2)
            begin n_fail++; $display("FAIL b2b_first: got %h stall %0d want bbccdd11 2", rd1, st1); end
        n_tests++; if (rd2 !== 32'hFFFFFFCC || st2 != 2)
            begin n_fail++; $display("FAIL b2b_second: got %h stall %0d want ffffffcc 2", rd2, st2); end
    endtask

    task automatic test_illegal_size();
        logic [31:0] rd; int st; logic er; int s;
        s = beat_a;
        access_a(1'b0, 3'd7, 32'h100, '0, rd, st, er);
        idle_a();
        n_tests++; if (er !== 1'b1 || st != 0 || beat_a != s)
            begin n_fail++; $display("FAIL size7_err: got err %b stall %0d beats %0d want 1 0 0", er, st, beat_a - s); end
    endtask

    task automatic test_misalign_disabled();
        logic [2:0]  sizes [0:1];
        logic [31:0] addrs [0:1];
        sizes[0] = 3'd1; addrs[0] = 32'h103;
        sizes[1] = 3'd3; addrs[1] = 32'h100;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            cb.req = 1'b1; cb.we = 1'b0; cb.size = sizes[k]; cb.addr = addrs[k];
            @(negedge clk);
            n_tests++; if (cb.err !== 1'b1 || cb.stall !== 1'b0)
                begin n_fail++; $display("FAIL noalign_err[%0d]: got err %b stall %b want 1 0", k, cb.err, cb.stall); end
            @(posedge clk); #1;
            cb.req = 1'b0;
            @(negedge clk);
            n_tests++; if (cb.err !== 1'b0) begin n_fail++; $display("FAIL noalign_err_drop[%0d]: got %b want 0", k, cb.err); end
        end
        n_tests++; if (req_b != 0) begin n_fail++; $display("FAIL noalign_no_beat: got %0d beat cycles want 0", req_b); end
    endtask

    task automatic test_rv64();
        logic [63:0] rd; int st; int s;
        s = beat_c;
        access_c(3'd3, 32'h104, rd, st);
        n_tests++; if (rd !== 64'hCCBBAA99_88776655) begin n_fail++; $display("FAIL ld_split_rd: got %h want ccbbaa9988776655", rd); end
        n_tests++; if (st != 3)                      begin n_fail++; $display("FAIL ld_split_stall: got %0d want 3", st); end
        n_tests++; if (logc_addr[s % 4] !== 32'h100 || logc_be[s % 4] !== 8'hF0 ||
                       logc_addr[(s + 1) % 4] !== 32'h108 || logc_be[(s + 1) % 4] !== 8'h0F)
            begin n_fail++; $display("FAIL ld_split_beats: got %h/%h %h/%h want 00000100/f0 00000108/0f",
                  logc_addr[s % 4], logc_be[s % 4], logc_addr[(s + 1) % 4], logc_be[(s + 1) % 4]); end
        s = beat_c;
        access_c(3'd2, 32'h104, rd, st);
        n_tests++; if (rd !== 64'hFFFFFFFF_88776655 || beat_c - s != 1 || logc_be[s % 4] !== 8'hF0)
            begin n_fail++; $display("FAIL lw64_rd: got %h beats %0d be %h want ffffffff88776655 1 f0", rd, beat_c - s, logc_be[s % 4]); end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd; int st; logic er; int s; logic found;
        delay_a = 2;
        found = 1'b0;
        @(posedge clk); #1;
        ca.req = 1'b1; ca.we = 1'b0; ca.size = 3'd2; ca.addr = 32'h102;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ma.req && ma.addr === 32'h104) begin found = 1'b1; break; end
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL midreset_reach_hi: HI beat not seen, required within 20 cycles"); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (ma.req !== 1'b0)   begin n_fail++; $display("FAIL midreset_req_drop: got %b want 0", ma.req); end
        n_tests++; if (ca.stall !== 1'b1 || ca.err !== 1'b0 || ca.rd !== 32'h0)
            begin n_fail++; $display("FAIL midreset_core: got stall %b err %b rd %h want 1 0 00000000", ca.stall, ca.err, ca.rd); end
        ca.req = 1'b0;
        delay_a = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        s = beat_a;
        access_a(1'b0, 3'd2, 32'h100, '0, rd, st, er);
        idle_a();
        n_tests++; if (rd !== 32'h44332211 || st != 2 || beat_a - s != 1)
            begin n_fail++; $display("FAIL post_reset_lw: got %h stall %0d beats %0d want 44332211 2 1", rd, st, beat_a - s); end
    endtask

    initial begin
        test_reset();
        test_lw_aligned();
        test_split_loads();
        test_wrap();
        test_store();
        test_wait_states();
        test_back_to_back();
        test_illegal_size();
        test_misalign_disabled();
        test_rv64();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000 time units, required to finish earlier");
        $fatal(1);
    end
endmodule
